// File: rtl/sobel_frame_capture_if.sv
// Stream/control bundle between the sobel frame capture block and its user.
// slave  : seen from the capture block (drives the o* signals).
// master : seen from the pixel source / readout sink (drives the i* signals).
interface sobel_frame_capture_if #(
  parameter int IN_W = 10
);
  logic            iARM;
  logic            iDVAL;
  logic [IN_W-1:0] iDATA;
  logic            oBUSY;
  logic            oFRAME_DONE;
  logic            oOVERRUN;
  logic            iRD_START;
  logic            oRD_VALID;
  logic            iRD_READY;
  logic [7:0]      oRD_DATA;
  logic            oRD_LAST;
  logic [15:0]     oCHECKSUM;

  modport slave (
    input  iARM, iDVAL, iDATA, iRD_START, iRD_READY,
    output oBUSY, oFRAME_DONE, oOVERRUN, oRD_VALID, oRD_DATA, oRD_LAST, oCHECKSUM
  );

  modport master (
    output iARM, iDVAL, iDATA, iRD_START, iRD_READY,
    input  oBUSY, oFRAME_DONE, oOVERRUN, oRD_VALID, oRD_DATA, oRD_LAST, oCHECKSUM
  );
endinterface

// File: rtl/sobel_frame_capture.sv
// Sobel frame capture: stores one raster frame (upper 8 bits of each pixel)
// into a frame RAM, then replays it in raster order over a valid/ready port.
// Optional macro CAPTURE_CHECKSUM_EN adds a 16-bit byte-sum of the captured frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | after reset, waiting for iARM
// S_CAPTURE | writing valid pixels to RAM until the last pixel of the frame
// S_DONE    | frame stored; waiting for iRD_START (readout) or iARM (recapture)
// S_READOUT | streaming stored bytes out until the byte flagged last is taken
module sobel_frame_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int IN_W     = 10,
  parameter int ADDR_W   = 17
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  sobel_frame_capture_if.slave  bus
);

  localparam int                N_PIX   = H_ACTIVE * V_ACTIVE;
  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_READOUT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_busy;

  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        r_ram_q;

  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              r_overrun;

  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_all;
  logic              r_pend;
  logic              r_pend_last;
  logic              r_out_vld;
  logic [7:0]        r_out_data;
  logic              r_out_last;
  logic              r_skid_vld;
  logic [7:0]        r_skid_data;
  logic              r_skid_last;

  logic              w_arm;
  logic              w_start;
  logic              w_wr;
  logic              w_wr_last;
  logic [7:0]        w_byte;
  logic              w_pop;
  logic              w_rd_done;
  logic              w_room;
  logic              w_issue;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_issue_last;
  logic              w_unused_lsb;

  // iARM outranks iRD_START when both arrive in DONE
  assign w_arm        = bus.iARM && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_start      = bus.iRD_START && (r_state == S_DONE) && !bus.iARM;
  assign w_wr         = (r_state == S_CAPTURE) && bus.iDVAL;
  assign w_wr_last    = w_wr && (r_wr_addr == LP_LAST);
  assign w_byte       = bus.iDATA[IN_W-1 -: 8];
  assign w_unused_lsb = ^bus.iDATA[IN_W-9:0];

  assign w_pop        = r_out_vld && bus.iRD_READY;
  assign w_rd_done    = w_pop && r_out_last;
  // a new read may be issued only if, after this cycle's pop, output reg + skid
  // + the read already in flight leave a free slot for its data next cycle
  assign w_room       = (r_out_vld && !w_pop) ? !(r_skid_vld || r_pend)
                                              : !(r_skid_vld && r_pend);
  // address 0 is read on the same edge that enters READOUT so the first byte
  // is presented two cycles after iRD_START
  assign w_issue      = w_start || ((r_state == S_READOUT) && !r_rd_all && w_room);
  assign w_rd_addr    = w_start ? '0 : r_rd_addr;
  assign w_issue_last = (w_rd_addr == LP_LAST);

  // state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_arm) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_wr_last) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_arm)        w_state_nxt = S_CAPTURE;
        else if (w_start) w_state_nxt = S_READOUT;
      end
      S_READOUT: if (w_rd_done) w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_busy = 1'b0;
    if ((r_state == S_CAPTURE) || (r_state == S_READOUT)) w_busy = 1'b1;
  end

  // frame RAM: one write port for capture, one registered read port for replay
  always_ff @(posedge iCLK) begin
    if (w_wr)    r_mem[r_wr_addr] <= w_byte;
    if (w_issue) r_ram_q <= r_mem[w_rd_addr];
  end

  // capture write pointer, frame-complete pulse and sticky overrun flag
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_wr_last;
      if (w_arm)     r_wr_addr <= '0;
      else if (w_wr) r_wr_addr <= w_wr_last ? '0 : r_wr_addr + ADDR_W'(1);
      // a pixel arriving on the arm cycle itself still counts as an overrun
      if (w_arm)                                    r_overrun <= bus.iDVAL;
      else if (bus.iDVAL && (r_state != S_CAPTURE)) r_overrun <= 1'b1;
    end
  end

  // readout pipeline: RAM read in flight -> output register, with a 1-entry
  // skid absorbing the in-flight byte when the sink stalls
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rd_addr   <= '0;
      r_rd_all    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
    end else begin
      r_pend      <= w_issue;
      r_pend_last <= w_issue && w_issue_last;
      if (w_issue) begin
        r_rd_addr <= w_rd_addr + ADDR_W'(1);
        r_rd_all  <= w_issue_last;
      end
      if (w_pop || !r_out_vld) begin
        if (r_skid_vld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= r_skid_data;
          r_out_last <= r_skid_last;
          r_skid_vld <= r_pend;
          if (r_pend) begin
            r_skid_data <= r_ram_q;
            r_skid_last <= r_pend_last;
          end
        end else begin
          r_out_vld  <= r_pend;
          r_out_last <= r_pend && r_pend_last;
          if (r_pend) r_out_data <= r_ram_q;
        end
      end else if (r_pend) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= r_ram_q;
        r_skid_last <= r_pend_last;
      end
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] r_acc;
  logic [15:0] r_checksum;

  // running byte sum of the frame; published when the frame completes
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_arm)     r_acc <= '0;
      else if (w_wr) r_acc <= r_acc + 16'(w_byte);
      if (w_wr_last) r_checksum <= r_acc + 16'(w_byte);
    end
  end

  assign bus.oCHECKSUM = r_checksum;
`else
  assign bus.oCHECKSUM = 16'h0000;
`endif

  assign bus.oBUSY       = w_busy;
  assign bus.oFRAME_DONE = r_frame_done;
  assign bus.oOVERRUN    = r_overrun;
  assign bus.oRD_VALID   = r_out_vld;
  assign bus.oRD_DATA    = r_out_data;
  assign bus.oRD_LAST    = r_out_last;

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Bench for sobel_frame_capture on a 4x3 frame: expected readout bytes are
// queued from a plain array model of the captured frame and popped by an
// independent monitor on every handshake.
module tb_sobel_frame_capture;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int N    = H * V;
  localparam int IN_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_capture_if #(.IN_W(IN_W)) bus ();

  sobel_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .IN_W(IN_W), .ADDR_W(4)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  model_mem[N];
  logic [9:0]  pix_in[N];
  logic [15:0] model_cs;
  int          done_pulses   = 0;
  int          done_expected = 0;
  logic        prev_stall    = 1'b0;
  logic [8:0]  prev_out      = '0;
  logic [8:0]  mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.oBUSY), 0);
    check({tag, "_done"},  32'(bus.oFRAME_DONE), 0);
    check({tag, "_ovr"},   32'(bus.oOVERRUN), 0);
    check({tag, "_valid"}, 32'(bus.oRD_VALID), 0);
    check({tag, "_data"},  32'(bus.oRD_DATA), 0);
    check({tag, "_last"},  32'(bus.oRD_LAST), 0);
    check({tag, "_cs"},    32'(bus.oCHECKSUM), 0);
  endtask

  // monitor: frame-done pulse count, stall stability, scoreboard pop on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.oFRAME_DONE) done_pulses++;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.oRD_VALID), 1);
        check("stall_hold", 32'({bus.oRD_LAST, bus.oRD_DATA}), 32'(prev_out));
      end
      if (bus.oRD_VALID && bus.iRD_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_extra: got %0h required no byte", {bus.oRD_LAST, bus.oRD_DATA});
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_byte", 32'({bus.oRD_LAST, bus.oRD_DATA}), 32'(mon_exp));
        end
      end
      prev_stall = bus.oRD_VALID && !bus.iRD_READY;
      prev_out   = {bus.oRD_LAST, bus.oRD_DATA};
    end
  end

  // capture n_pix pixels of pix_in; mode 1 inserts an idle cycle between pixels;
  // inject_at pulses iARM and iRD_START alongside that pixel
  task automatic capture(input bit do_arm, input int mode, input int n_pix, input int inject_at);
    logic [15:0] sum;
    sum = '0;
    if (do_arm) begin
      @(posedge clk); #1;
      bus.iARM = 1'b1;
      @(posedge clk); #1;
      bus.iARM = 1'b0;
      @(negedge clk);
      check("arm_busy", 32'(bus.oBUSY), 1);
      check("arm_ovr_clr", 32'(bus.oOVERRUN), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < n_pix; i++) begin
      if (mode == 1 && i > 0) begin
        bus.iDVAL = 1'b0;
        @(posedge clk); #1;
      end
      bus.iDVAL = 1'b1;
      bus.iDATA = pix_in[i];
      if (i == inject_at) begin
        bus.iARM      = 1'b1;
        bus.iRD_START = 1'b1;
      end
      model_mem[i] = pix_in[i] >> 2;
      sum          = sum + 16'(pix_in[i] >> 2);
      @(posedge clk); #1;
      bus.iARM      = 1'b0;
      bus.iRD_START = 1'b0;
    end
    bus.iDVAL = 1'b0;
    @(negedge clk);
    if (n_pix == N) begin
      done_expected++;
`ifdef CAPTURE_CHECKSUM_EN
      model_cs = sum;
`else
      model_cs = 16'h0000;
`endif
      check("frame_done", 32'(bus.oFRAME_DONE), 1);
      check("done_idle", 32'(bus.oBUSY), 0);
      check("checksum", 32'(bus.oCHECKSUM), 32'(model_cs));
    end else begin
      check("mid_busy", 32'(bus.oBUSY), 1);
    end
  endtask

  // stream the frame out; mode 0 keeps ready high, mode 1 randomises it;
  // abort_cyc > 0 asserts reset at that cycle while a byte is presented
  task automatic readout(input int mode, input int abort_cyc);
    int c;
    int first;
    int last_c;
    bit fin;
    bit aborted;
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), model_mem[i]});
    @(posedge clk); #1;
    bus.iRD_START = 1'b1;
    bus.iRD_READY = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    c = 0; first = -1; last_c = -1; fin = 0; aborted = 0;
    while (!fin && c < 200) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.iRD_START = 1'b0;
        bus.iRD_READY = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (first < 0 && bus.oRD_VALID) first = c;
      if (abort_cyc > 0 && c == abort_cyc) begin
        check("pre_abort_valid", 32'(bus.oRD_VALID), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rd_abort");
        exp_q.delete();
        bus.iRD_READY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1; aborted = 1;
      end else if (bus.oRD_VALID && bus.iRD_READY && bus.oRD_LAST) begin
        fin = 1; last_c = c;
      end
      c++;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL rd_timeout: got no last byte within %0d cycles required one", c);
    end
    if (!aborted) begin
      check("first_valid_lat", 32'(first), 2);
      if (mode == 0) check("no_bubbles", 32'(last_c), 32'(N + 1));
      @(posedge clk); #1;
      bus.iRD_READY = 1'b0;
      @(negedge clk);
      check("valid_drop", 32'(bus.oRD_VALID), 0);
      check("rd_busy_end", 32'(bus.oBUSY), 0);
      check("queue_empty", 32'(exp_q.size()), 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.iARM = 1'b0; bus.iDVAL = 1'b0; bus.iDATA = '0;
    bus.iRD_START = 1'b0; bus.iRD_READY = 1'b0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ramp frame, back-to-back, always-ready readout
    for (int k = 0; k < N; k++) pix_in[k] = 10'(k << 2);
    capture(1, 0, N, -1);
    readout(0, 0);

    // same frame with bubbles and random ready, then random frames
    capture(1, 1, N, -1);
    readout(1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) pix_in[k] = 10'($urandom);
      capture(1, r % 2, N, -1);
      readout(1, 0);
    end

    // overrun in IDLE, cleared by arm; overrun in DONE writes nothing
    pulse_reset();
    @(posedge clk); #1;
    bus.iDVAL = 1'b1; bus.iDATA = 10'h3FF;
    @(posedge clk); #1;
    bus.iDVAL = 1'b0;
    @(negedge clk);
    check("ovr_idle", 32'(bus.oOVERRUN), 1);
    check("ovr_idle_busy", 32'(bus.oBUSY), 0);
    for (int k = 0; k < N; k++) pix_in[k] = 10'($urandom);
    capture(1, 0, N, -1);
    @(posedge clk); #1;
    bus.iDVAL = 1'b1; bus.iDATA = 10'h3FF;
    @(posedge clk); #1;
    bus.iDVAL = 1'b0;
    @(negedge clk);
    check("ovr_done", 32'(bus.oOVERRUN), 1);
    readout(1, 0);

    // iARM/iRD_START ignored in CAPTURE; both together in DONE -> recapture
    for (int k = 0; k < N; k++) pix_in[k] = 10'($urandom);
    capture(1, 0, N, 4);
    @(posedge clk); #1;
    bus.iARM = 1'b1; bus.iRD_START = 1'b1;
    @(posedge clk); #1;
    bus.iARM = 1'b0; bus.iRD_START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("both_busy", 32'(bus.oBUSY), 1);
      check("both_no_valid", 32'(bus.oRD_VALID), 0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) pix_in[k] = 10'($urandom);
    capture(0, 1, N, -1);
    readout(1, 0);

    // reset mid-capture and mid-readout, then a clean frame
    capture(1, 0, 7, -1);
    rst_n = 1'b0;
    #1;
    check_all_zero("cap_abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) pix_in[k] = 10'($urandom);
    capture(1, 0, N, -1);
    readout(0, 5);
    capture(1, 0, N, -1);
    readout(1, 0);

    // saturated pixels: checksum 12 * 0xFF
    for (int k = 0; k < N; k++) pix_in[k] = 10'h3FF;
    capture(1, 0, N, -1);
`ifdef CAPTURE_CHECKSUM_EN
    check("cs_full", 32'(bus.oCHECKSUM), 32'h0BF4);
`else
    check("cs_off", 32'(bus.oCHECKSUM), 32'h0000);
`endif
    readout(0, 0);

    @(negedge clk);
    check("done_pulse_count", 32'(done_pulses), 32'(done_expected));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end
endmodule
